// File: rtl/adder_pipe_sat_if.sv
// Purpose: handshake + operand/result bundle for adder_pipe_sat.
// Latency: none (wires only).
// Backpressure: in_ready is driven by the slave from out_ready.
interface adder_pipe_sat_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         sat;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  // Environment / upstream+downstream view.
  modport master (
    output in_valid, a, b, cin, sub, sat, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // Adder view.
  modport slave (
    input  in_valid, a, b, cin, sub, sat, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/adder_pipe_sat.sv
// Purpose: pipelined signed add/sub, SEG bits of carry chain per stage, wrap or saturate.
// Latency: W/SEG cycles from the accepting edge to out_valid.
// Backpressure: global stall; in_ready = !out_valid || out_ready, all stages hold otherwise.
module adder_pipe_sat #(
  parameter int W   = 8,
  parameter int SEG = 4
) (
  input  logic           clk,
  input  logic           rst,
  adder_pipe_sat_if.slave bus
);
  localparam int STAGES = W / SEG;

  // One pipeline slot: partial sum so far, carry into the next slice, and
  // the full effective operands carried along so later stages can slice them.
  typedef struct packed {
    logic         vld;
    logic         cy;
    logic         sat;
    logic [W-1:0] s;
    logic [W-1:0] a;
    logic [W-1:0] bp;
  } stage_t;

  stage_t [STAGES-1:0] st;
  stage_t [STAGES-1:0] nx;

  logic         advance;
  logic         out_valid_q;
  logic [W-1:0] sum_q;
  logic         cout_q;
  logic         ovf_q;
  logic [W-1:0] sum_n;
  logic         ovf_n;

  // A single stall signal freezes the whole pipe; a slot frees up as soon as
  // the output is empty or being taken this cycle.
  assign advance       = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

  // Per-stage slice addition: stage 0 takes the raw inputs, stage i the
  // registered slot i-1; each adds its own SEG-bit slice plus incoming carry.
  always_comb begin
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] s_in;
    logic         c_in;
    logic         v_in;
    logic         sat_in;
    logic [SEG:0] seg;
    int           p;
    nx     = st;
    op_a   = '0;
    op_b   = '0;
    s_in   = '0;
    c_in   = 1'b0;
    v_in   = 1'b0;
    sat_in = 1'b0;
    seg    = '0;
    p      = 0;
    for (int i = 0; i < STAGES; i++) begin
      p = (i > 0) ? i - 1 : 0;
      if (i == 0) begin
        op_a   = bus.a;
        op_b   = bus.sub ? ~bus.b : bus.b;
        c_in   = bus.sub | bus.cin;
        v_in   = bus.in_valid;
        s_in   = '0;
        sat_in = bus.sat;
      end else begin
        op_a   = st[p].a;
        op_b   = st[p].bp;
        c_in   = st[p].cy;
        v_in   = st[p].vld;
        s_in   = st[p].s;
        sat_in = st[p].sat;
      end
      seg = {1'b0, op_a[i*SEG +: SEG]} + {1'b0, op_b[i*SEG +: SEG]} + {{SEG{1'b0}}, c_in};
      s_in[i*SEG +: SEG] = seg[SEG-1:0];
      nx[i].vld = v_in;
      nx[i].cy  = seg[SEG];
      nx[i].sat = sat_in;
      nx[i].a   = op_a;
      nx[i].bp  = op_b;
      nx[i].s   = s_in;
    end
  end

  // Overflow and saturation on the completed raw sum in the last slot.
  always_comb begin
    ovf_n = (st[STAGES-1].a[W-1] == st[STAGES-1].bp[W-1]) &&
            (st[STAGES-1].s[W-1] != st[STAGES-1].a[W-1]);
    sum_n = st[STAGES-1].s;
    if (st[STAGES-1].sat && ovf_n) begin
      sum_n = st[STAGES-1].a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

  // Pipeline and output registers; reset drops everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (advance) begin
      st          <= nx;
      out_valid_q <= st[STAGES-1].vld;
      if (st[STAGES-1].vld) begin
        sum_q  <= sum_n;
        cout_q <= st[STAGES-1].cy;
        ovf_q  <= ovf_n;
      end
    end
  end
endmodule

// File: tb/tb_adder_pipe_sat.sv
// Purpose: self-checking bench for adder_pipe_sat at W=8/SEG=4 and W=16/SEG=4.
// Latency: checks 2-cycle latency on the 8-bit instance.
// Backpressure: exercises held out_ready and random out_ready.
module tb_adder_pipe_sat;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  adder_pipe_sat_if #(.W(8))  i8 ();
  adder_pipe_sat_if #(.W(16)) i16 ();

  adder_pipe_sat #(.W(8),  .SEG(4)) dut8  (.clk(clk), .rst(rst), .bus(i8.slave));
  adder_pipe_sat #(.W(16), .SEG(4)) dut16 (.clk(clk), .rst(rst), .bus(i16.slave));

  int   total = 0;
  int   bad   = 0;
  exp_t q8[$];
  exp_t q16[$];

  // Plain whole-word reference for a w-bit add/sub with optional saturation.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub, input logic sat);
    logic [16:0] full;
    logic [15:0] mask;
    logic [15:0] bp;
    logic [15:0] raw;
    exp_t        r;
    mask   = 16'hFFFF >> (16 - w);
    bp     = (sub ? ~b : b) & mask;
    full   = {1'b0, a & mask} + {1'b0, bp} + {16'b0, (sub | cin)};
    raw    = full[15:0] & mask;
    r.cout = full[w];
    r.ovf  = (a[w-1] == bp[w-1]) && (raw[w-1] != a[w-1]);
    if (sat && r.ovf) raw = a[w-1] ? (16'h1 << (w - 1)) : (mask >> 1);
    r.sum  = raw;
    return r;
  endfunction

  task automatic test_reset();
    i8.in_valid = 0; i8.out_ready = 1; i8.a = 0; i8.b = 0; i8.cin = 0; i8.sub = 0; i8.sat = 0;
    i16.in_valid = 0; i16.out_ready = 1; i16.a = 0; i16.b = 0; i16.cin = 0; i16.sub = 0; i16.sat = 0;
    #1 rst = 1'b1;
    #3;
    total++;
    if (i8.out_valid !== 1'b0 || i8.sum !== 8'h00 || i8.cout !== 1'b0 || i8.ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_out8: valid=%b sum=%h cout=%b ovf=%b required 0/00/0/0",
               i8.out_valid, i8.sum, i8.cout, i8.ovf);
    end
    total++;
    if (i8.in_ready !== 1'b1 || i16.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b/%b required 1/1", i8.in_ready, i16.in_ready);
    end
    total++;
    if (i16.out_valid !== 1'b0 || i16.sum !== 16'h0000) begin
      bad++;
      $display("FAIL reset_out16: valid=%b sum=%h required 0/0000", i16.out_valid, i16.sum);
    end
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (i8.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_valid: got %b required 0", i8.out_valid);
    end
  endtask

  task automatic test_one(input string nm, input logic [7:0] ta, input logic [7:0] tb_,
                          input logic tcin, input logic tsub, input logic tsat,
                          input logic [7:0] es, input logic ec, input logic eo);
    int   lat;
    exp_t e;
    q8.push_back('{sum: {8'h00, es}, cout: ec, ovf: eo});
    i8.a = ta; i8.b = tb_; i8.cin = tcin; i8.sub = tsub; i8.sat = tsat;
    i8.out_ready = 1'b1;
    i8.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    i8.in_valid = 1'b0;
    lat = 0;
    while (!i8.out_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    total++;
    if (lat != 2) begin
      bad++;
      $display("FAIL %s_latency: got %0d required 2", nm, lat);
    end
    total++;
    if (q8.size() == 0) begin
      bad++;
      $display("FAIL %s_queue: result with no expected entry", nm);
    end else begin
      e = q8.pop_front();
      if (i8.out_valid !== 1'b1 || i8.sum !== e.sum[7:0] || i8.cout !== e.cout || i8.ovf !== e.ovf) begin
        bad++;
        $display("FAIL %s: valid=%b sum=%h cout=%b ovf=%b required 1 sum=%h cout=%b ovf=%b",
                 nm, i8.out_valid, i8.sum, i8.cout, i8.ovf, e.sum[7:0], e.cout, e.ovf);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int   sent = 0;
    int   got  = 0;
    int   hold = 0;
    int   cyc  = 0;
    exp_t e;
    i8.cin = 0; i8.sub = 0; i8.sat = 0;
    while (got < 4 && cyc < 40) begin
      i8.out_ready = (hold == 0);
      i8.in_valid  = (sent < 4);
      i8.a = 8'(sent + 1);
      i8.b = 8'(sent + 1);
      #1;
      if (hold > 0) begin
        total++;
        if (i8.in_ready !== 1'b0 || i8.out_valid !== 1'b1 || q8.size() == 0 || i8.sum !== q8[0].sum[7:0]) begin
          bad++;
          $display("FAIL b2b_hold: in_ready=%b valid=%b sum=%h required 0/1/held result",
                   i8.in_ready, i8.out_valid, i8.sum);
        end
        hold--;
      end
      if (i8.out_valid && i8.out_ready) begin
        total++;
        if (q8.size() == 0) begin
          bad++;
          $display("FAIL b2b_extra: unexpected result sum=%h", i8.sum);
        end else begin
          e = q8.pop_front();
          if (i8.sum !== e.sum[7:0] || i8.cout !== e.cout || i8.ovf !== e.ovf) begin
            bad++;
            $display("FAIL b2b_result%0d: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                     got, i8.sum, i8.cout, i8.ovf, e.sum[7:0], e.cout, e.ovf);
          end
        end
        got++;
        if (got == 1) hold = 3;
      end
      if (i8.in_valid && i8.in_ready) begin
        q8.push_back('{sum: 16'(2 * (sent + 1)), cout: 1'b0, ovf: 1'b0});
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    i8.in_valid  = 1'b0;
    i8.out_ready = 1'b1;
    total++;
    if (got != 4 || q8.size() != 0) begin
      bad++;
      $display("FAIL b2b_count: got=%0d left=%0d required 4/0", got, q8.size());
    end
  endtask

  task automatic test_reset_midstream();
    int stale = 0;
    i8.out_ready = 1'b1;
    i8.cin = 0; i8.sub = 0; i8.sat = 0;
    for (int j = 0; j < 3; j++) begin
      i8.a = (j == 0) ? 8'h7F : 8'(8'h20 + j);
      i8.b = (j == 0) ? 8'h01 : 8'h11;
      i8.in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    i8.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if (i8.out_valid !== 1'b0 || i8.sum !== 8'h00 || i8.cout !== 1'b0 || i8.ovf !== 1'b0) begin
      bad++;
      $display("FAIL midreset_out: valid=%b sum=%h cout=%b ovf=%b required 0/00/0/0",
               i8.out_valid, i8.sum, i8.cout, i8.ovf);
    end
    total++;
    if (i8.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset_in_ready: got %b required 1", i8.in_ready);
    end
    q8.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk);
      #1;
      if (i8.out_valid) stale++;
    end
    total++;
    if (stale != 0) begin
      bad++;
      $display("FAIL midreset_stale: got %0d stale results required 0", stale);
    end
  endtask

  task automatic test_random16();
    int   sent = 0;
    int   got  = 0;
    int   cyc  = 0;
    exp_t e;
    while ((sent < 5000 || got < 5000) && cyc < 40000) begin
      i16.out_ready = ($urandom_range(0, 3) != 0);
      i16.in_valid  = (sent < 5000) && ($urandom_range(0, 4) != 0);
      i16.a   = 16'($urandom);
      i16.b   = 16'($urandom);
      i16.cin = 1'($urandom);
      i16.sub = 1'($urandom);
      i16.sat = 1'($urandom);
      #1;
      if (i16.out_valid && i16.out_ready) begin
        total++;
        if (q16.size() == 0) begin
          bad++;
          $display("FAIL rand_extra: unexpected result sum=%h", i16.sum);
        end else begin
          e = q16.pop_front();
          if (i16.sum !== e.sum || i16.cout !== e.cout || i16.ovf !== e.ovf) begin
            bad++;
            $display("FAIL rand_result%0d: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                     got, i16.sum, i16.cout, i16.ovf, e.sum, e.cout, e.ovf);
          end
        end
        got++;
      end
      if (i16.in_valid && i16.in_ready) begin
        q16.push_back(model(16, i16.a, i16.b, i16.cin, i16.sub, i16.sat));
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    i16.in_valid  = 1'b0;
    i16.out_ready = 1'b1;
    total++;
    if (sent != 5000 || got != 5000 || q16.size() != 0) begin
      bad++;
      $display("FAIL rand_count: sent=%0d got=%0d left=%0d required 5000/5000/0", sent, got, q16.size());
    end
  endtask

  initial begin
    test_reset();
    test_one("add_ovf_wrap",  8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    test_one("add_ovf_sat",   8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
    test_one("sub_ovf_wrap",  8'h80, 8'h01, 1'b0, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
    test_one("sub_ovf_sat",   8'h80, 8'h01, 1'b0, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1);
    test_one("sub_neg",       8'h05, 8'h07, 1'b0, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
    test_one("sub_cin_ignored", 8'h05, 8'h07, 1'b1, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
    test_one("add_carry_out", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    test_one("add_cin_chain", 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    test_one("add_neg_sat",   8'h80, 8'h80, 1'b0, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1);
    test_back_to_back();
    test_reset_midstream();
    test_one("after_reset",   8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
    test_random16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/adder_pipe_sat.md
# adder_pipe_sat

Parametrised, pipelined signed adder/subtractor, successor to the 8-bit ripple adder. The W-bit carry chain is split into SEG-bit segments, with one register stage per segment, so clock rate is independent of width. Each transaction selects add or subtract and wrap or saturate, and reports carry-out and signed overflow. A valid/ready handshake on both sides lets the block sit directly in the datapath ahead of or behind the multiplier.

## Interface
- W, 8, operand/result width in bits; must be a multiple of SEG, W ≥ 2
- SEG, 4, bits added per pipeline stage; STAGES = W/SEG is the latency in cycles
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input transaction present
- in_ready  out  1  block accepts the input this cycle
- a  in  W  operand A, two's complement
- b  in  W  operand B, two's complement
- cin  in  1  carry-in; used for add only
- sub  in  1  1: A − B, 0: A + B + cin
- sat  in  1  1: saturate on signed overflow, 0: wrap
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts the result
- sum  out  W  result
- cout  out  1  raw unsigned carry-out of bit W−1 (unsaturated)
- ovf  out  1  signed overflow of this transaction

## Operation
- Effective operands: A, B' = sub ? ~B : B, and c0 = sub ? 1 : cin. cin is ignored when sub = 1.
- Stage i (0..STAGES−1) adds bits [i·SEG +: SEG] of A and B' plus the carry registered from stage i−1 (c0 for stage 0). It registers the SEG sum bits and its carry.
- Unprocessed upper operand slices, the sign bits of A and B', sub and sat travel alongside in skew registers. Lower-sum slices travel forward unchanged.
- Final stage:
  - ovf = (A[W−1] == B'[W−1]) && (raw_sum[W−1] != A[W−1])
  - cout = carry out of bit W−1
  - sum = raw_sum when !(sat && ovf)
  - sum = A[W−1] ? {1, 0…0} (most negative) : {0, 1…1} (most positive) when sat && ovf
- Global stall, with advance = !out_valid || out_ready:
  - in_ready = advance.
  - When advance = 0, every stage register, every valid bit and the outputs hold.
- A transfer occurs on an edge where in_valid && in_ready. Stage-0 valid loads in_valid && advance.
- Bubbles propagate as invalid stages and are not compressed.
- Results leave strictly in input order, with no loss or duplication.
- Reset (at any time, including mid-stream):
  - all valid bits → 0; in-flight transactions are discarded
  - sum → 0, cout → 0, ovf → 0, out_valid → 0
  - in_ready is 1 while out_valid = 0, including during reset

## Timing
- Latency: a transaction accepted at edge k appears with out_valid = 1 after edge k+STAGES. For W=8, SEG=4 that is 2 cycles.
- Throughput: one transaction per cycle while out_ready = 1.
- out_valid, sum, cout and ovf are registered and stay stable while out_valid && !out_ready.
- in_ready depends combinationally on out_ready. No other input-to-output combinational path exists.
- Simultaneous out_ready = 1 and in_valid = 1 with a full pipeline: the output is consumed and the input is accepted on the same edge.
- W = SEG (STAGES = 1) is legal and gives a single-cycle registered adder.

## Test plan
- W=8, SEG=4, a=0x7F, b=0x01, sub=0, cin=0, sat=0 → after 2 cycles, sum=0x80, ovf=1, cout=0. The same inputs with sat=1 → sum=0x7F, ovf=1.
- a=0x80, b=0x01, sub=1: sat=0 → sum=0x7F, ovf=1, cout=1. sat=1 → sum=0x80, ovf=1. a=0x05, b=0x07, sub=1 → sum=0xFE, ovf=0, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. a=0x0F, b=0x00, cin=1 → sum=0x10, which exercises the inter-stage carry.
- Stream 0x01+0x01, 0x02+0x02, 0x03+0x03, 0x04+0x04 back-to-back, holding out_ready=0 for 3 cycles after the first result:
  - required: in_ready=0 during the hold and sum 0x02, 0x04, 0x06, 0x08 in order with no drop or duplicate.
- Assert rst for 1 cycle asynchronously, mid-cycle, with 2 transactions in flight → out_valid=0, sum=0, cout=0 and ovf=0 immediately. No stale result appears afterwards, and the next accepted transaction returns correctly after 2 cycles.
- W=16, SEG=4: 5000 random transactions with random sub, sat, cin and out_ready → every result matches the reference model; ovf and cout match for all.
